// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default parameters for debounce_sync.
package debounce_pkg;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   // bit 1 of the encoding equals the debounced level
   localparam logic [1:0] ENC_LOW  = 2'b00;
   localparam logic [1:0] ENC_RISE = 2'b01;
   localparam logic [1:0] ENC_HIGH = 2'b11;
   localparam logic [1:0] ENC_FALL = 2'b10;
   typedef enum logic [1:0] {
      S_LOW  = ENC_LOW,
      S_RISE = ENC_RISE,
      S_HIGH = ENC_HIGH,
      S_FALL = ENC_FALL
   } state_t;
endpackage

// File: rtl/debounce_sync_chain.sv
// sync_chain: STAGES-deep reset-to-0 flop chain bringing an asynchronous level into the clk domain.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic asyncResetN,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;
   always_ff @(posedge clk or negedge asyncResetN)
      if (!asyncResetN) ff <= '0;
      else ff <= {ff[STAGES-2:0], d};
   assign q = ff[STAGES-1];
endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes and debounces a bouncing input level into dOut.
// Define DEBOUNCE_PULSE_EN to get registered riseP/fallP edge pulses; otherwise they are tied to 0.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic asyncResetN,
   input  logic rawIn,
   output logic dOut,
   output logic riseP,
   output logic fallP
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic sync_in;
   logic done;
   state_t state;
   logic [CNT_W-1:0] cnt;
   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .asyncResetN(asyncResetN),
      .d          (rawIn),
      .q          (sync_in)
   );
   // the current sample is the last one needed to accept the new level
   assign done = (cnt == LAST);
   always_ff @(posedge clk or negedge asyncResetN)
      if (!asyncResetN) begin
         state <= S_LOW;
         cnt   <= '0;
         dOut  <= 1'b0;
      end else begin
         case (state)
            S_LOW: begin
               state <= sync_in ? S_RISE : S_LOW;
               cnt   <= CNT_W'(sync_in);
            end
            S_RISE:
               if (!sync_in) begin
                  state <= S_LOW;
                  cnt   <= '0;
               end else if (done) begin
                  state <= S_HIGH;
                  cnt   <= '0;
                  dOut  <= 1'b1;
               end else cnt <= cnt + CNT_W'(1);
            S_HIGH: begin
               state <= sync_in ? S_HIGH : S_FALL;
               cnt   <= CNT_W'(!sync_in);
            end
            S_FALL:
               if (sync_in) begin
                  state <= S_HIGH;
                  cnt   <= '0;
               end else if (done) begin
                  state <= S_LOW;
                  cnt   <= '0;
                  dOut  <= 1'b0;
               end else cnt <= cnt + CNT_W'(1);
            default: begin
               state <= S_LOW;
               cnt   <= '0;
               dOut  <= 1'b0;
            end
         endcase
      end
`ifdef DEBOUNCE_PULSE_EN
   always_ff @(posedge clk or negedge asyncResetN)
      if (!asyncResetN) begin
         riseP <= 1'b0;
         fallP <= 1'b0;
      end else begin
         riseP <= (state == S_RISE) && sync_in && done;
         fallP <= (state == S_FALL) && !sync_in && done;
      end
`else
   assign riseP = 1'b0;
   assign fallP = 1'b0;
`endif
endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops; legal range is 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the consecutive stable synchronized cycles required to accept a level change; legal range is 2..65535.
REQ-004 Port clk  input  1  SHALL be the rising-edge clock for all state.
REQ-005 Port asyncResetN  input  1  SHALL be the asynchronous active-low reset.
REQ-006 Port rawIn  input  1  SHALL be the asynchronous, possibly bouncing, level from a switch or pin.
REQ-007 Port dOut  output  1  SHALL be the debounced, clk-synchronous level that drives the D input of the downstream D flip-flop.
REQ-008 Port riseP  output  1  SHALL be a one-cycle pulse marking the cycle in which dOut goes 0->1.
REQ-009 Port fallP  output  1  SHALL be a one-cycle pulse marking the cycle in which dOut goes 1->0.

Function
REQ-010 rawIn SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is syncIn, and no other logic SHALL sample rawIn.
REQ-011 The FSM SHALL have four states: S_LOW, S_RISE, S_HIGH, S_FALL; dOut SHALL be 1 exactly in S_HIGH and S_FALL.
REQ-012 The counter cnt SHALL be CNT_W = clog2(DEBOUNCE_CYCLES) bits wide, unsigned, and SHALL never wrap.
REQ-013 S_LOW with syncIn=1 SHALL go to S_RISE with cnt=1; with syncIn=0 it SHALL stay in S_LOW with cnt=0.
REQ-014 S_RISE with syncIn=0 SHALL return to S_LOW with cnt=0 and SHALL emit no pulse (glitch rejected).
REQ-015 S_RISE with syncIn=1 and cnt=DEBOUNCE_CYCLES-1 SHALL go to S_HIGH, set dOut=1, assert riseP for that one cycle, and clear cnt; otherwise it SHALL increment cnt.
REQ-016 S_HIGH, S_FALL and fallP SHALL mirror REQ-013..REQ-015 with syncIn inverted.
REQ-017 For rawIn held stable from the first sampling edge (edge 1), dOut SHALL change on edge SYNC_STAGES+DEBOUNCE_CYCLES; the default latency is 18 edges.
REQ-018 riseP and fallP SHALL be registered, SHALL never both be 1, and SHALL never be 1 in consecutive cycles.
REQ-019 A bounce train whose high runs are all shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave dOut unchanged.

Reset
REQ-020 On asyncResetN=0, the block SHALL immediately clear all sync flops, cnt, dOut, riseP and fallP to 0 and set the state to S_LOW, independent of clk.
REQ-021 Reset asserted mid-count SHALL abort the count with no pulse; after release, debouncing SHALL restart from S_LOW.
REQ-022 If rawIn=1 at reset release, dOut SHALL rise after the full REQ-017 latency, with riseP asserted.

Configuration
REQ-023 With DEBOUNCE_PULSE_EN defined, riseP and fallP SHALL behave per REQ-008, REQ-009 and REQ-018.
REQ-024 Without DEBOUNCE_PULSE_EN, the ports SHALL remain, SHALL be tied to constant 0, and no pulse flops SHALL be synthesized; dOut behaviour SHALL be unchanged.

Structure
REQ-025 Package debounce_pkg SHALL hold the state typedef (S_LOW, S_RISE, S_HIGH, S_FALL), the encoding constants, and the default SYNC_STAGES and DEBOUNCE_CYCLES values.
REQ-026 The synchronizer chain SHALL be a sub-module sync_chain (parameter STAGES, ports clk, asyncResetN, d, q), reset to 0.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-027 With rawIn 0->1 held -> dOut=1 on edge 6, riseP=1 on edge 6 only, and fallP=0 throughout.
REQ-028 With rawIn=1 pulse for 3 cycles, then 0 -> dOut stays 0 and no pulse is emitted.
REQ-029 With a bounce of 1,0,1,1,0,1 followed by 1 held -> exactly one riseP, 6 edges after the last 0->1 sample.
REQ-030 With dOut=1 and rawIn 1->0 held -> dOut=0 and fallP=1 on edge 6.
REQ-031 With asyncResetN pulsed low between clock edges in S_RISE at cnt=2 -> all outputs 0 immediately; after release, the full 6-edge latency is required.
REQ-032 With DEBOUNCE_PULSE_EN undefined, rerunning the REQ-027 stimulus -> identical dOut, and riseP=fallP=0 always.
